// File: rtl/hms_clock_counter.sv
// BCD time-of-day counter advanced by a synchronized 1 Hz input, with preset, pause
// and registered active-low 7-segment decode of all six digits.
module hms_clock_counter #(
    parameter int HOUR_MAX   = 23,
    parameter int SYNC_DEPTH = 2
) (
    input  logic       clock50,
    input  logic       reset_n,
    input  logic       clock1,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0
);

    localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [6:0] SEG_ZERO     = 7'b1000000;

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;
    logic                  rise;
    logic [7:0]            ss_inc;
    logic [7:0]            mm_inc;
    logic [7:0]            hh_inc;
    logic                  ss_wrap;
    logic                  mm_wrap;
    logic                  hh_wrap;
    logic                  ld_valid;

    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // clock1 is treated purely as data; prev_q is the edge-detect history
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], clock1};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign rise = sync_q[SYNC_DEPTH-1] & ~prev_q;

    always_comb begin
        ss_inc  = inc_sixty(ss);
        mm_inc  = inc_sixty(mm);
        hh_wrap = (hh == HOUR_MAX_BCD);
        hh_inc  = 8'h00;
        if (!hh_wrap) begin
            hh_inc = (hh[3:0] == 4'd9) ? {hh[7:4] + 4'd1, 4'd0} : {hh[7:4], hh[3:0] + 4'd1};
        end
        ss_wrap = (ss == 8'h59);
        mm_wrap = (mm == 8'h59);
    end

    // BCD order matches numeric order once each digit is known to be <= 9
    assign ld_valid = (ld_hh[7:4] <= 4'd9) && (ld_hh[3:0] <= 4'd9) &&
                      (ld_mm[7:4] <= 4'd9) && (ld_mm[3:0] <= 4'd9) &&
                      (ld_ss[7:4] <= 4'd9) && (ld_ss[3:0] <= 4'd9) &&
                      (ld_ss <= 8'h59) && (ld_mm <= 8'h59) && (ld_hh <= HOUR_MAX_BCD);

    // load has priority; a rise in the same cycle is dropped, not deferred
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (ld_valid) begin
                    hh <= ld_hh;
                    mm <= ld_mm;
                    ss <= ld_ss;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (rise && run) begin
                sec_tick <= 1'b1;
                ss       <= ss_inc;
                if (ss_wrap) begin
                    mm <= mm_inc;
                    if (mm_wrap) begin
                        hh       <= hh_inc;
                        day_wrap <= hh_wrap;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            hex5 <= SEG_ZERO;
            hex4 <= SEG_ZERO;
            hex3 <= SEG_ZERO;
            hex2 <= SEG_ZERO;
            hex1 <= SEG_ZERO;
            hex0 <= SEG_ZERO;
        end else begin
            hex5 <= seg7(hh[7:4]);
            hex4 <= seg7(hh[3:0]);
            hex3 <= seg7(mm[7:4]);
            hex2 <= seg7(mm[3:0]);
            hex1 <= seg7(ss[7:4]);
            hex0 <= seg7(ss[3:0]);
        end
    end

endmodule

// File: tb/tb_hms_clock_counter.sv
// Scoreboard bench for hms_clock_counter: stimulus tasks push expected time events,
// a negedge monitor pops and compares them (including cycle of arrival and hex decode).
module tb_hms_clock_counter;

    localparam int HOUR_MAX = 23;

    logic       clock50 = 1'b0;
    logic       reset_n;
    logic       clock1;
    logic       run;
    logic       load;
    logic [7:0] ld_hh, ld_mm, ld_ss;
    logic [7:0] hh, mm, ss;
    logic       sec_tick, day_wrap, load_err;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

    hms_clock_counter #(.HOUR_MAX(HOUR_MAX), .SYNC_DEPTH(2)) dut (
        .clock50(clock50), .reset_n(reset_n), .clock1(clock1), .run(run), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
        .hh(hh), .mm(mm), .ss(ss),
        .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    always #5 clock50 = ~clock50;

    typedef struct {
        string      tag;
        int         cyc;
        logic [7:0] h, m, s;
        logic       tick, wrap, err;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc   = 0;
    int   m_h = 0, m_m = 0, m_s = 0;

    always @(posedge clock50) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;  4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;  4'd9: s = 7'b0010000;
            default: s = 7'bxxxxxxx;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [23:0] model_time();
        return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
    endfunction

    // monitor: any pulse or time change is a DUT output event
    logic [23:0] prev_t = '0;
    logic        hex_due = 1'b0;
    logic [23:0] hex_t;
    always @(negedge clock50) begin
        if (!reset_n) begin
            prev_t  = '0;
            hex_due = 1'b0;
        end else begin
            if (hex_due) begin
                chk("hex5", hex5, seg(hex_t[23:20]));
                chk("hex4", hex4, seg(hex_t[19:16]));
                chk("hex3", hex3, seg(hex_t[15:12]));
                chk("hex2", hex2, seg(hex_t[11:8]));
                chk("hex1", hex1, seg(hex_t[7:4]));
                chk("hex0", hex0, seg(hex_t[3:0]));
                hex_due = 1'b0;
            end
            if (sec_tick || day_wrap || load_err || ({hh, mm, ss} != prev_t)) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", q.size(), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.tag, "_cycle"}, cyc, e.cyc);
                    chk({e.tag, "_time"}, {hh, mm, ss}, {e.h, e.m, e.s});
                    chk({e.tag, "_sec_tick"}, sec_tick, e.tick);
                    chk({e.tag, "_day_wrap"}, day_wrap, e.wrap);
                    chk({e.tag, "_load_err"}, load_err, e.err);
                    hex_due = 1'b1;
                    hex_t   = {e.h, e.m, e.s};
                end
                prev_t = {hh, mm, ss};
            end
        end
    end

    task automatic push(input string tag, input int at, input logic t, input logic w, input logic er);
        exp_t e;
        e.tag = tag; e.cyc = at;
        e.h = to_bcd(m_h); e.m = to_bcd(m_m); e.s = to_bcd(m_s);
        e.tick = t; e.wrap = w; e.err = er;
        q.push_back(e);
    endtask

    task automatic apply_load(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bit ok;
        ok = (h[7:4] <= 9) && (h[3:0] <= 9) && (m[7:4] <= 9) && (m[3:0] <= 9) &&
             (s[7:4] <= 9) && (s[3:0] <= 9) && (from_bcd(s) <= 59) && (from_bcd(m) <= 59) &&
             (from_bcd(h) <= HOUR_MAX);
        ld_hh = h; ld_mm = m; ld_ss = s; load = 1'b1;
        if (ok) begin
            m_h = from_bcd(h); m_m = from_bcd(m); m_s = from_bcd(s);
        end
        push(tag, cyc + 1, 1'b0, 1'b0, !ok);
    endtask

    // one clock1 period; called just after a posedge
    task automatic pulse(input string tag, input int hold, input bit with_ld,
                         input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        int  k;
        bit  wrap;
        k = cyc;
        clock1 = 1'b1;
        if (!with_ld && run) begin
            wrap = 1'b0;
            m_s++;
            if (m_s == 60) begin
                m_s = 0; m_m++;
                if (m_m == 60) begin
                    m_m = 0; m_h++;
                    if (m_h > HOUR_MAX) begin m_h = 0; wrap = 1'b1; end
                end
            end
            push(tag, k + 3, 1'b1, wrap, 1'b0);
        end
        repeat (2) @(posedge clock50);
        #1;
        if (with_ld) apply_load(tag, h, m, s);
        @(posedge clock50); #1;
        load = 1'b0;
        repeat (hold) @(posedge clock50);
        #1 clock1 = 1'b0;
        repeat (5) @(posedge clock50);
        #1;
    endtask

    task automatic tick_once(input string tag);
        pulse(tag, 6, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_load(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        apply_load(tag, h, m, s);
        @(posedge clock50); #1;
        load = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clock50);
        repeat (2) @(posedge clock50);
        #1;
        chk({tag, "_drained"}, q.size(), 0);
        chk({tag, "_model"}, {hh, mm, ss}, model_time());
    endtask

    initial begin
        reset_n = 1'b0; clock1 = 1'b0; run = 1'b0; load = 1'b0;
        ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00;
        repeat (3) @(posedge clock50);
        #1 reset_n = 1'b1;
        @(posedge clock50); #1;
        chk("rst_time", {hh, mm, ss}, 24'h000000);
        chk("rst_pulses", {sec_tick, day_wrap, load_err}, 3'b000);
        chk("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'b1000000}});

        // reset while showing 12:34:56
        do_load("t1_load", 8'h12, 8'h34, 8'h56);
        drain("t1_pre");
        reset_n = 1'b0;
        m_h = 0; m_m = 0; m_s = 0;
        #1;
        chk("t1_time", {hh, mm, ss}, 24'h000000);
        chk("t1_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'b1000000}});
        chk("t1_pulses", {sec_tick, day_wrap, load_err}, 3'b000);
        @(posedge clock50); #1 reset_n = 1'b1;
        @(posedge clock50); #1;

        // latency and a long-held high clock1
        run = 1'b1;
        pulse("t2_rise", 2000, 1'b0, 8'h00, 8'h00, 8'h00);
        drain("t2");

        // carries
        do_load("t3_load_a", 8'h23, 8'h59, 8'h58);
        tick_once("t3_to_235959");
        tick_once("t3_day_wrap");
        drain("t3a");
        do_load("t3_load_b", 8'h09, 8'h59, 8'h59);
        tick_once("t3_to_100000");
        drain("t3b");

        // load validation
        do_load("t4_bad_hh", 8'h24, 8'h00, 8'h00);
        do_load("t4_bad_mm", 8'h12, 8'h60, 8'h00);
        do_load("t4_bad_nib", 8'h12, 8'h0A, 8'h00);
        do_load("t4_good", 8'h12, 8'h34, 8'h56);
        drain("t4");

        // collision and pause
        pulse("t5_collide", 6, 1'b1, 8'h05, 8'h00, 8'h00);
        drain("t5a");
        run = 1'b0;
        repeat (3) tick_once("t5_paused");
        drain("t5b");
        run = 1'b1;
        tick_once("t5_resume");
        drain("t5c");

        // reset between rise and update, clock1 dropped during reset
        @(posedge clock50); #1 clock1 = 1'b1;
        @(posedge clock50); #1 reset_n = 1'b0; clock1 = 1'b0;
        m_h = 0; m_m = 0; m_s = 0;
        @(posedge clock50); #1 reset_n = 1'b1;
        repeat (10) @(posedge clock50);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
